// File: rtl/dbg_sb_pkg.sv
// Shared types and bus field widths for the debug system-bus masters.
package dbg_sb_pkg;

    localparam int BURST_W_DEF = 8;
    localparam int SB_AD_W     = 32;
    localparam int SB_BE_W     = 4;
    localparam int SB_BSZ_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_BEGIN,
        ST_WRITE,
        ST_READ,
        ST_END,
        ST_ABORT
    } sb_state_e;

endpackage

// File: rtl/dbg_sb_watchdog.sv
// Progress watchdog: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT_CYCLES have elapsed; saturates until cleared.
module dbg_sb_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_d, count_q;

    // Clear has priority over counting; counter holds at the limit.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) count_q <= '0;
        else          count_q <= count_d;
    end

    assign expired_o = (count_q == CNT_MAX);

endmodule

// File: rtl/dbg_sb_master.sv
// Debug system-bus master: one burst command at a time, bus arbitration,
// begin/data/end sequencing, completion / error / timeout reporting.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a command, bus outputs quiet
// REQ      | requesting the bus, waiting for grant
// BEGIN    | one cycle: address, burst size, byte enables, direction
// WRITE    | streaming write words, holding a word while slave is busy
// READ     | collecting read beats until the slave ends the transfer
// END      | one cycle: end-of-transaction strobe
// ABORT    | one cycle: bus error or watchdog, end strobe if bus owned
module dbg_sb_master
    import dbg_sb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int BURST_W        = BURST_W_DEF
) (
    input  logic                sb_clock_i,
    input  logic                sb_reset_n_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_write_i,
    input  logic [31:0]         cmd_address_i,
    input  logic [BURST_W-1:0]  cmd_burst_i,
    input  logic [3:0]          cmd_byte_enables_i,
    input  logic [31:0]         wdata_i,
    input  logic                wdata_valid_i,
    output logic                wdata_ready_o,
    output logic [31:0]         rdata_o,
    output logic                rdata_valid_o,
    output logic                done_o,
    output logic                error_o,
    output logic                sb_request_o,
    input  logic                sb_grant_i,
    output logic [31:0]         sb_address_data_o,
    output logic [3:0]          sb_byte_enables_o,
    output logic [7:0]          sb_burst_size_o,
    output logic                sb_read_n_write_o,
    output logic                sb_begin_transaction_o,
    output logic                sb_end_transaction_o,
    output logic                sb_data_valid_o,
    input  logic [31:0]         sb_address_data_i,
    input  logic                sb_end_transaction_i,
    input  logic                sb_data_valid_i,
    input  logic                sb_busy_i,
    input  logic                sb_error_i
);

    localparam int CW = BURST_W + 1;
    localparam logic [CW-1:0] ONE = CW'(1);

    sb_state_e              state_d, state_q;
    logic                   write_d, write_q;
    logic [SB_AD_W-1:0]     addr_d, addr_q;
    logic [BURST_W-1:0]     burst_d, burst_q;
    logic [SB_BE_W-1:0]     cmd_be_d, cmd_be_q;
    logic [CW-1:0]          beats_left_d, beats_left_q;
    logic [CW-1:0]          words_left_d, words_left_q;
    logic                   cmd_ready_d, cmd_ready_q;
    logic                   request_d, request_q;
    logic                   begin_d, begin_q;
    logic                   end_d, end_q;
    logic [SB_AD_W-1:0]     ad_d, ad_q;
    logic [SB_BE_W-1:0]     be_d, be_q;
    logic [SB_BSZ_W-1:0]    bsz_d, bsz_q;
    logic                   rnw_d, rnw_q;
    logic                   dv_d, dv_q;
    logic                   done_d, done_q;
    logic                   error_d, error_q;
    logic [31:0]            rdata_d, rdata_q;
    logic                   rdata_valid_d, rdata_valid_q;

    logic wd_clear, wd_enable, wd_expired;
    logic beat_accept, read_beat, wdata_load;

    dbg_sb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk_i     (sb_clock_i),
        .rst_n_i   (sb_reset_n_i),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    // Next word may be loaded whenever the output slot is free or draining.
    assign wdata_ready_o = ((state_q == ST_BEGIN) || (state_q == ST_WRITE)) && write_q &&
                           (words_left_q != '0) && (!dv_q || !sb_busy_i);
    assign wdata_load  = wdata_ready_o && wdata_valid_i;
    assign beat_accept = (state_q == ST_WRITE) && dv_q && !sb_busy_i;
    assign read_beat   = (state_q == ST_READ) && sb_data_valid_i && (beats_left_q != '0);

    // Next-state, command latch, beat counting, status pulses, read capture.
    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        addr_d        = addr_q;
        burst_d       = burst_q;
        cmd_be_d      = cmd_be_q;
        beats_left_d  = beats_left_q;
        words_left_d  = words_left_q;
        done_d        = 1'b0;
        error_d       = 1'b0;
        rdata_d       = '0;
        rdata_valid_d = 1'b0;
        wd_clear      = 1'b0;
        wd_enable     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    write_d      = cmd_write_i;
                    addr_d       = cmd_address_i;
                    burst_d      = cmd_burst_i;
                    cmd_be_d     = cmd_byte_enables_i;
                    beats_left_d = CW'(cmd_burst_i) + ONE;
                    words_left_d = CW'(cmd_burst_i) + ONE;
                    wd_clear     = 1'b1;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                wd_enable = 1'b1;
                if (sb_grant_i) begin
                    wd_clear = 1'b1;
                    state_d  = ST_BEGIN;
                end else if (wd_expired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_BEGIN: begin
                if (sb_error_i) state_d = ST_ABORT;
                else            state_d = write_q ? ST_WRITE : ST_READ;
            end
            ST_WRITE: begin
                wd_enable = 1'b1;
                if (beat_accept) begin
                    beats_left_d = beats_left_q - ONE;
                    wd_clear     = 1'b1;
                end
                if (sb_error_i)                                state_d = ST_ABORT;
                else if (beat_accept && beats_left_q == ONE)   state_d = ST_END;
                else if (!beat_accept && wd_expired)           state_d = ST_ABORT;
            end
            ST_READ: begin
                wd_enable = 1'b1;
                if (read_beat) begin
                    beats_left_d = beats_left_q - ONE;
                    wd_clear     = 1'b1;
                    if (!sb_error_i) begin
                        rdata_d       = sb_address_data_i;
                        rdata_valid_d = 1'b1;
                    end
                end
                if (sb_error_i) begin
                    state_d = ST_ABORT;
                end else if (sb_end_transaction_i) begin
                    state_d = ST_IDLE;
                    // A slave ending early is a short read.
                    if (beats_left_d == '0) done_d  = 1'b1;
                    else                    error_d = 1'b1;
                end else if (!read_beat && wd_expired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_END: begin
                if (sb_error_i) begin
                    state_d = ST_ABORT;
                end else begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
                error_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (wdata_load) words_left_d = words_left_q - ONE;
    end

    // Bus and handshake outputs decoded from the state being entered, so
    // every bus output is a flop and is quiet whenever the bus is not owned.
    always_comb begin
        cmd_ready_d = 1'b0;
        request_d   = 1'b0;
        begin_d     = 1'b0;
        end_d       = 1'b0;
        ad_d        = '0;
        be_d        = '0;
        bsz_d       = '0;
        rnw_d       = 1'b0;
        dv_d        = 1'b0;
        case (state_d)
            ST_IDLE: cmd_ready_d = 1'b1;
            ST_REQ, ST_READ: request_d = 1'b1;
            ST_BEGIN: begin
                request_d = 1'b1;
                begin_d   = 1'b1;
                ad_d      = addr_q;
                be_d      = cmd_be_q;
                bsz_d     = SB_BSZ_W'(burst_q);
                rnw_d     = !write_q;
            end
            ST_WRITE: begin
                request_d = 1'b1;
                if (wdata_load) begin
                    ad_d = wdata_i;
                    dv_d = 1'b1;
                end else if (dv_q && sb_busy_i) begin
                    ad_d = ad_q;
                    dv_d = 1'b1;
                end
            end
            ST_END: begin
                request_d = 1'b1;
                end_d     = 1'b1;
            end
            ST_ABORT: end_d = (state_q != ST_REQ);
            default: ;
        endcase
    end

    // State, command and output registers.
    always_ff @(posedge sb_clock_i or negedge sb_reset_n_i) begin
        if (!sb_reset_n_i) begin
            state_q       <= ST_IDLE;
            write_q       <= 1'b0;
            addr_q        <= '0;
            burst_q       <= '0;
            cmd_be_q      <= '0;
            beats_left_q  <= '0;
            words_left_q  <= '0;
            cmd_ready_q   <= 1'b0;
            request_q     <= 1'b0;
            begin_q       <= 1'b0;
            end_q         <= 1'b0;
            ad_q          <= '0;
            be_q          <= '0;
            bsz_q         <= '0;
            rnw_q         <= 1'b0;
            dv_q          <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            addr_q        <= addr_d;
            burst_q       <= burst_d;
            cmd_be_q      <= cmd_be_d;
            beats_left_q  <= beats_left_d;
            words_left_q  <= words_left_d;
            cmd_ready_q   <= cmd_ready_d;
            request_q     <= request_d;
            begin_q       <= begin_d;
            end_q         <= end_d;
            ad_q          <= ad_d;
            be_q          <= be_d;
            bsz_q         <= bsz_d;
            rnw_q         <= rnw_d;
            dv_q          <= dv_d;
            done_q        <= done_d;
            error_q       <= error_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    assign cmd_ready_o            = cmd_ready_q;
    assign sb_request_o           = request_q;
    assign sb_begin_transaction_o = begin_q;
    assign sb_end_transaction_o   = end_q;
    assign sb_address_data_o      = ad_q;
    assign sb_byte_enables_o      = be_q;
    assign sb_burst_size_o        = bsz_q;
    assign sb_read_n_write_o      = rnw_q;
    assign sb_data_valid_o        = dv_q;
    assign done_o                 = done_q;
    assign error_o                = error_q;
    assign rdata_o                = rdata_q;
    assign rdata_valid_o          = rdata_valid_q;

endmodule

// File: tb/tb_dbg_sb_master.sv
// Bench for dbg_sb_master: per-scenario expected output traces are built from
// the bus timing rules (request/begin/beats/end/done positions), then every
// cycle of the run is compared against them.
module tb_dbg_sb_master;

    localparam int TO   = 16;
    localparam int MAXT = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid_i, cmd_ready_o, cmd_write_i;
    logic [31:0] cmd_address_i;
    logic [7:0]  cmd_burst_i;
    logic [3:0]  cmd_byte_enables_i;
    logic [31:0] wdata_i;
    logic        wdata_valid_i, wdata_ready_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, done_o, error_o;
    logic        sb_request_o, sb_grant_i;
    logic [31:0] sb_address_data_o;
    logic [3:0]  sb_byte_enables_o;
    logic [7:0]  sb_burst_size_o;
    logic        sb_read_n_write_o, sb_begin_transaction_o, sb_end_transaction_o, sb_data_valid_o;
    logic [31:0] sb_address_data_i;
    logic        sb_end_transaction_i, sb_data_valid_i, sb_busy_i, sb_error_i;

    always #5 clk = ~clk;

    dbg_sb_master #(.TIMEOUT_CYCLES(TO), .BURST_W(8)) dut (
        .sb_clock_i             (clk),
        .sb_reset_n_i           (rst_n),
        .cmd_valid_i            (cmd_valid_i),
        .cmd_ready_o            (cmd_ready_o),
        .cmd_write_i            (cmd_write_i),
        .cmd_address_i          (cmd_address_i),
        .cmd_burst_i            (cmd_burst_i),
        .cmd_byte_enables_i     (cmd_byte_enables_i),
        .wdata_i                (wdata_i),
        .wdata_valid_i          (wdata_valid_i),
        .wdata_ready_o          (wdata_ready_o),
        .rdata_o                (rdata_o),
        .rdata_valid_o          (rdata_valid_o),
        .done_o                 (done_o),
        .error_o                (error_o),
        .sb_request_o           (sb_request_o),
        .sb_grant_i             (sb_grant_i),
        .sb_address_data_o      (sb_address_data_o),
        .sb_byte_enables_o      (sb_byte_enables_o),
        .sb_burst_size_o        (sb_burst_size_o),
        .sb_read_n_write_o      (sb_read_n_write_o),
        .sb_begin_transaction_o (sb_begin_transaction_o),
        .sb_end_transaction_o   (sb_end_transaction_o),
        .sb_data_valid_o        (sb_data_valid_o),
        .sb_address_data_i      (sb_address_data_i),
        .sb_end_transaction_i   (sb_end_transaction_i),
        .sb_data_valid_i        (sb_data_valid_i),
        .sb_busy_i              (sb_busy_i),
        .sb_error_i             (sb_error_i)
    );

    int vectors = 0;
    int miscompares = 0;
    string scn;

    // stimulus tables
    logic        st_grant[MAXT], st_busy[MAXT], st_sdv[MAXT], st_send[MAXT], st_serr[MAXT];
    logic [31:0] st_sdata[MAXT];
    // expected traces
    logic        exp_cr[MAXT], exp_wr[MAXT], exp_req[MAXT], exp_beg[MAXT], exp_end[MAXT];
    logic        exp_dv[MAXT], exp_rnw[MAXT], exp_done[MAXT], exp_err[MAXT], exp_rv[MAXT];
    logic [3:0]  exp_be[MAXT];
    logic [7:0]  exp_bsz[MAXT];
    logic [31:0] exp_ad[MAXT], exp_rd[MAXT];

    logic        c_write;
    logic [31:0] c_addr;
    logic [7:0]  c_burst;
    logic [3:0]  c_be;
    logic [31:0] wwords[8];
    int load_idx;
    int end_t, done_t, done_cnt, err_t, err_cnt, rv_cnt;

    function automatic logic [85:0] out_vec();
        return {cmd_ready_o, wdata_ready_o, sb_request_o, sb_begin_transaction_o,
                sb_end_transaction_o, sb_data_valid_o, sb_read_n_write_o, sb_byte_enables_o,
                sb_burst_size_o, sb_address_data_o, done_o, error_o, rdata_valid_o, rdata_o};
    endfunction

    task automatic clear_tables();
        for (int t = 0; t < MAXT; t++) begin
            st_grant[t] = 0; st_busy[t] = 0; st_sdv[t] = 0; st_send[t] = 0; st_serr[t] = 0;
            st_sdata[t] = '0;
            exp_cr[t] = 0; exp_wr[t] = 0; exp_req[t] = 0; exp_beg[t] = 0; exp_end[t] = 0;
            exp_dv[t] = 0; exp_rnw[t] = 0; exp_done[t] = 0; exp_err[t] = 0; exp_rv[t] = 0;
            exp_be[t] = '0; exp_bsz[t] = '0; exp_ad[t] = '0; exp_rd[t] = '0;
        end
        load_idx = 0;
        end_t = -1; done_t = -1; done_cnt = 0; err_t = -1; err_cnt = 0; rv_cnt = 0;
    endtask

    task automatic set_cmd(input logic wr, input logic [31:0] a, input int n, input logic [3:0] be,
                           input int g, input logic [31:0] wbase);
        c_write = wr; c_addr = a; c_burst = 8'(n - 1); c_be = be;
        for (int k = 0; k < 8; k++) wwords[k] = wbase + 32'h0101_0101 * k;
        if (g >= 0) for (int t = g; t < MAXT; t++) st_grant[t] = 1'b1;
    endtask

    task automatic model_begin(input int g, input logic rnw);
        exp_cr[0] = 1'b1;
        for (int u = 1; u <= g; u++) exp_req[u] = 1'b1;
        exp_req[g+1] = 1'b1; exp_beg[g+1] = 1'b1; exp_ad[g+1] = c_addr;
        exp_be[g+1] = c_be; exp_bsz[g+1] = c_burst; exp_rnw[g+1] = rnw;
    endtask

    // Write: each word stays on the bus until a non-busy cycle takes it; the
    // next word is fetched in BEGIN and in every accepting cycle but the last.
    // te >= 0 is a bus-error cycle: abort end strobe next, error after that.
    task automatic model_write(input int g, input int n, input int te);
        int t;
        bit stop;
        stop = 0;
        model_begin(g, 1'b0);
        exp_wr[g+1] = 1'b1;
        t = g + 2;
        for (int k = 0; k < n && !stop; k++) begin
            bit acc;
            acc = 0;
            while (!acc && !stop) begin
                exp_req[t] = 1'b1; exp_dv[t] = 1'b1; exp_ad[t] = wwords[k];
                if (!st_busy[t]) begin
                    acc = 1;
                    if (k < n - 1) exp_wr[t] = 1'b1;
                end
                if (t == te) stop = 1;
                t++;
            end
        end
        if (stop) begin
            exp_end[t] = 1'b1; exp_err[t+1] = 1'b1;
        end else begin
            exp_req[t] = 1'b1; exp_end[t] = 1'b1; exp_done[t+1] = 1'b1;
        end
        for (int u = t + 1; u < MAXT; u++) exp_cr[u] = 1'b1;
    endtask

    // Read: first n slave beats echo one cycle later; slave end at te gives
    // done if all n arrived, otherwise error.
    task automatic model_read(input int g, input int n, input int te);
        int cnt;
        cnt = 0;
        model_begin(g, 1'b1);
        for (int t = g + 2; t <= te; t++) begin
            exp_req[t] = 1'b1;
            if (st_sdv[t] && cnt < n) begin
                exp_rv[t+1] = 1'b1; exp_rd[t+1] = st_sdata[t]; cnt++;
            end
        end
        if (cnt == n) exp_done[te+1] = 1'b1;
        else          exp_err[te+1]  = 1'b1;
        for (int u = te + 1; u < MAXT; u++) exp_cr[u] = 1'b1;
    endtask

    task automatic model_timeout();
        exp_cr[0] = 1'b1;
        for (int u = 1; u <= TO + 1; u++) exp_req[u] = 1'b1;
        exp_err[TO+3] = 1'b1;
        for (int u = TO + 3; u < MAXT; u++) exp_cr[u] = 1'b1;
    endtask

    task automatic drive(input int t);
        cmd_valid_i          = (t == 0);
        cmd_write_i          = c_write;
        cmd_address_i        = c_addr;
        cmd_burst_i          = c_burst;
        cmd_byte_enables_i   = c_be;
        sb_grant_i           = st_grant[t];
        sb_busy_i            = st_busy[t];
        sb_data_valid_i      = st_sdv[t];
        sb_address_data_i    = st_sdata[t];
        sb_end_transaction_i = st_send[t];
        sb_error_i           = st_serr[t];
        wdata_valid_i        = 1'b1;
        wdata_i              = wwords[(load_idx < 8) ? load_idx : 7];
    endtask

    task automatic check(input int t);
        logic [85:0] act, want;
        act  = out_vec();
        want = {exp_cr[t], exp_wr[t], exp_req[t], exp_beg[t], exp_end[t], exp_dv[t], exp_rnw[t],
                exp_be[t], exp_bsz[t], exp_ad[t], exp_done[t], exp_err[t], exp_rv[t], exp_rd[t]};
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s cycle %0d outputs got=%h want=%h", scn, t, act, want);
        end
        if (sb_end_transaction_o) end_t = t;
        if (done_o) begin done_cnt++; done_t = t; end
        if (error_o) begin err_cnt++; err_t = t; end
        if (rdata_valid_o) rv_cnt++;
    endtask

    task automatic run(input int len);
        for (int t = 0; t < len; t++) begin
            @(posedge clk); #1;
            drive(t);
            @(negedge clk);
            check(t);
            if (wdata_ready_o && wdata_valid_i) load_idx++;
        end
    endtask

    task automatic pin(input string nm, input int act, input int want);
        vectors++;
        if (act != want) begin
            miscompares++;
            $display("FAIL %s %s got=%0d want=%0d", scn, nm, act, want);
        end
    endtask

    task automatic pin_quiet(input string nm);
        vectors++;
        if (out_vec() !== '0) begin
            miscompares++;
            $display("FAIL %s %s got=%h want=0", scn, nm, out_vec());
        end
    endtask

    initial begin
        rst_n = 1'b1;
        c_write = 0; c_addr = '0; c_burst = '0; c_be = '0;
        for (int k = 0; k < 8; k++) wwords[k] = '0;
        clear_tables();
        drive(1);
        cmd_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #3;
        scn = "reset";
        pin_quiet("outputs_in_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        scn = "write4";
        clear_tables();
        set_cmd(1'b1, 32'h1000_0040, 4, 4'hF, 3, 32'hA0A0_0000);
        model_write(3, 4, -1);
        run(13);
        pin("end_cycle", end_t, 9);
        pin("done_cycle", done_t, 10);
        pin("done_count", done_cnt, 1);

        scn = "write2_busy";
        clear_tables();
        set_cmd(1'b1, 32'h2000_0000, 2, 4'h3, 1, 32'h5555_0000);
        st_busy[3] = 1; st_busy[4] = 1; st_busy[5] = 1;
        model_write(1, 2, -1);
        run(12);
        pin("done_cycle", done_t, 9);

        scn = "read2";
        clear_tables();
        set_cmd(1'b0, 32'h3000_0010, 2, 4'hF, 2, 32'h0);
        st_sdv[4] = 1; st_sdata[4] = 32'hDEAD_BEEF;
        st_sdv[5] = 1; st_sdata[5] = 32'h1234_5678;
        st_send[6] = 1;
        model_read(2, 2, 6);
        run(10);
        pin("done_cycle", done_t, 7);
        pin("rvalid_count", rv_cnt, 2);

        scn = "short_read";
        clear_tables();
        set_cmd(1'b0, 32'h4000_0000, 4, 4'hC, 1, 32'h0);
        st_sdv[3] = 1; st_sdata[3] = 32'hCAFE_0001;
        st_sdv[4] = 1; st_sdata[4] = 32'hCAFE_0002;
        st_send[5] = 1;
        model_read(1, 4, 5);
        run(9);
        pin("error_cycle", err_t, 6);
        pin("done_count", done_cnt, 0);

        scn = "timeout";
        clear_tables();
        set_cmd(1'b1, 32'h5000_0000, 1, 4'hF, -1, 32'h7777_0000);
        model_timeout();
        run(22);
        pin("error_cycle", err_t, 19);
        pin("error_count", err_cnt, 1);

        scn = "bus_error_write";
        clear_tables();
        set_cmd(1'b1, 32'h6000_0000, 4, 4'hF, 1, 32'h9000_0000);
        st_serr[5] = 1;
        model_write(1, 4, 5);
        run(10);
        pin("end_cycle", end_t, 6);
        pin("error_cycle", err_t, 7);

        scn = "reset_mid_write";
        clear_tables();
        set_cmd(1'b1, 32'h7000_0000, 4, 4'hF, 1, 32'hB000_0000);
        model_write(1, 4, -1);
        run(4);
        @(posedge clk); #1;
        drive(4);
        #2 rst_n = 1'b0;
        #1 pin_quiet("outputs_at_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        scn = "read_after_reset";
        clear_tables();
        set_cmd(1'b0, 32'h8000_0100, 1, 4'h1, 1, 32'h0);
        st_sdv[3] = 1; st_sdata[3] = 32'h0BAD_F00D;
        st_sdv[4] = 1; st_sdata[4] = 32'h0000_0055;
        st_send[5] = 1;
        model_read(1, 1, 5);
        run(9);
        pin("done_cycle", done_t, 6);
        pin("rvalid_count", rv_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
